// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one block memory between the data and instruction caches.
// Grant at the request posedge, memory latency + 3 cycles minimum; losers and stalled winners see busywait held high.
module mem_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic [DATA_W-1:0] dc_writedata,
  output logic [DATA_W-1:0] dc_readdata,
  output logic              dc_busywait,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_address,
  output logic [DATA_W-1:0] ic_readdata,
  output logic              ic_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_DC, ISSUE_IC, WAIT_DC, WAIT_IC, DONE_DC, DONE_IC
  } state_t;

  localparam logic GRANT_DC = 1'b0;
  localparam logic GRANT_IC = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0] dc_readdata_q, dc_readdata_d;
  logic [DATA_W-1:0] ic_readdata_q, ic_readdata_d;

  logic dc_req;
  logic ic_req;

  // Simultaneous read and write from the data cache is treated as no request.
  assign dc_req = dc_read ^ dc_write;
  assign ic_req = ic_read;

  assign dc_busywait   = dc_req && (state_q != DONE_DC);
  assign ic_busywait   = ic_req && (state_q != DONE_IC);
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign dc_readdata   = dc_readdata_q;
  assign ic_readdata   = ic_readdata_q;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    dc_readdata_d   = dc_readdata_q;
    ic_readdata_d   = ic_readdata_q;

    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (dc_req && (!ic_req || last_grant_q == GRANT_IC)) begin
          mem_read_d      = dc_read;
          mem_write_d     = dc_write;
          mem_address_d   = dc_address;
          mem_writedata_d = dc_writedata;
          state_d         = ISSUE_DC;
        end else if (ic_req) begin
          mem_read_d    = 1'b1;
          mem_address_d = ic_address;
          state_d       = ISSUE_IC;
        end
      end
      // Memory may raise busywait a cycle late, so the issue cycle never samples it.
      ISSUE_DC: state_d = WAIT_DC;
      ISSUE_IC: state_d = WAIT_IC;
      WAIT_DC: begin
        if (!mem_busywait) begin
          if (mem_read_q) dc_readdata_d = mem_readdata;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = GRANT_DC;
          state_d      = DONE_DC;
        end
      end
      WAIT_IC: begin
        if (!mem_busywait) begin
          ic_readdata_d = mem_readdata;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          last_grant_d  = GRANT_IC;
          state_d       = DONE_IC;
        end
      end
      DONE_DC: state_d = IDLE;
      DONE_IC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_IC;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      dc_readdata_q   <= '0;
      ic_readdata_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      dc_readdata_q   <= dc_readdata_d;
      ic_readdata_q   <= ic_readdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a fixed-latency block memory model.
module tb_mem_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dc_read = 1'b0, dc_write = 1'b0;
  logic [5:0]  dc_address = '0;
  logic [31:0] dc_writedata = '0;
  logic [31:0] dc_readdata;
  logic        dc_busywait;
  logic        ic_read = 1'b0;
  logic [5:0]  ic_address = '0;
  logic [31:0] ic_readdata;
  logic        ic_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait;

  int total = 0;
  int bad = 0;
  int lat = 1;
  int cnt = 0;
  int both_hi = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address),
    .dc_writedata(dc_writedata), .dc_readdata(dc_readdata), .dc_busywait(dc_busywait),
    .ic_read(ic_read), .ic_address(ic_address), .ic_readdata(ic_readdata),
    .ic_busywait(ic_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  // Memory holds busywait for 'lat' cycles after the first posedge that sees a request.
  always @(posedge clock) begin
    if (!(mem_read || mem_write)) cnt <= 0;
    else if (cnt < lat) cnt <= cnt + 1;
  end
  assign mem_busywait = (mem_read || mem_write) && (cnt < lat);

  always @(negedge clock) if (mem_read && mem_write) both_hi <= both_hi + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_release(input bit ic_side, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((ic_side ? ic_busywait : dc_busywait) && n < 40);
  endtask

  int n;
  int ic_low;
  logic [5:0] grants [4];

  initial begin
    tick(); tick();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_dc_readdata", dc_readdata, 32'd0);
    chk("rst_ic_readdata", ic_readdata, 32'd0);
    chk("rst_busywaits", 32'({dc_busywait, ic_busywait}), 32'd0);
    reset = 1'b0;
    tick();

    // DC read, 5-cycle memory
    lat = 5; mem_readdata = 32'hDEADBEEF;
    dc_read = 1'b1; dc_address = 6'h15;
    #1;
    chk("t1_busy_same_cycle", 32'(dc_busywait), 32'd1);
    tick();
    chk("t1_mem_read", 32'(mem_read), 32'd1);
    chk("t1_mem_write", 32'(mem_write), 32'd0);
    chk("t1_mem_address", 32'(mem_address), 32'h15);
    chk("t1_ic_busy_grant", 32'(ic_busywait), 32'd0);
    wait_release(1'b0, n);
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_dc_readdata", dc_readdata, 32'hDEADBEEF);
    chk("t1_mem_read_clr", 32'(mem_read), 32'd0);
    chk("t1_ic_busy_done", 32'(ic_busywait), 32'd0);
    tick();
    chk("t1_busy_one_cycle", 32'(dc_busywait), 32'd1);
    dc_read = 1'b0;
    tick();
    chk("t1_no_regrant", 32'(mem_read), 32'd0);

    // DC write; request fields change mid-grant
    lat = 3;
    dc_write = 1'b1; dc_address = 6'h07; dc_writedata = 32'h12345678;
    tick();
    chk("t2_mem_write", 32'(mem_write), 32'd1);
    chk("t2_mem_read", 32'(mem_read), 32'd0);
    chk("t2_mem_writedata", mem_writedata, 32'h12345678);
    dc_address = 6'h3F; dc_writedata = 32'h0;
    tick();
    chk("t2_addr_latched", 32'(mem_address), 32'h07);
    chk("t2_wdata_latched", mem_writedata, 32'h12345678);
    wait_release(1'b0, n);
    chk("t2_latency_rest", 32'(n), 32'd3);
    chk("t2_dc_readdata_kept", dc_readdata, 32'hDEADBEEF);
    chk("t2_mem_write_clr", 32'(mem_write), 32'd0);
    dc_write = 1'b0;
    tick();

    // Simultaneous requests right after reset: DC first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 2; mem_readdata = 32'hA0A0A0A0;
    dc_read = 1'b1; dc_address = 6'h0A; ic_read = 1'b1; ic_address = 6'h0B;
    tick();
    chk("t3_dc_first_addr", 32'(mem_address), 32'h0A);
    ic_low = 0;
    n = 0;
    do begin
      if (!ic_busywait) ic_low++;
      tick();
      n++;
    end while (dc_busywait && n < 40);
    if (!ic_busywait) ic_low++;
    chk("t3_ic_held_busy", 32'(ic_low), 32'd0);
    chk("t3_dc_latency", 32'(n), 32'd3);
    chk("t3_dc_readdata", dc_readdata, 32'hA0A0A0A0);
    dc_read = 1'b0; mem_readdata = 32'hB0B0B0B0;
    tick();
    chk("t3_idle_ic_busy", 32'(ic_busywait), 32'd1);
    tick();
    chk("t3_ic_grant_read", 32'(mem_read), 32'd1);
    chk("t3_ic_grant_addr", 32'(mem_address), 32'h0B);
    wait_release(1'b1, n);
    chk("t3_ic_latency", 32'(n), 32'd3);
    chk("t3_ic_readdata", ic_readdata, 32'hB0B0B0B0);
    chk("t3_dc_readdata_kept", dc_readdata, 32'hA0A0A0A0);
    ic_read = 1'b0;
    tick();

    // Continuous contention: grants alternate
    lat = 1;
    dc_read = 1'b1; dc_address = 6'h11; ic_read = 1'b1; ic_address = 6'h22;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!mem_read && n < 20) begin tick(); n++; end
      grants[t] = mem_address;
      n = 0;
      while (mem_read && n < 20) begin tick(); n++; end
    end
    dc_read = 1'b0; ic_read = 1'b0;
    chk("t4_grant0", 32'(grants[0]), 32'h11);
    chk("t4_grant1", 32'(grants[1]), 32'h22);
    chk("t4_grant2", 32'(grants[2]), 32'h11);
    chk("t4_grant3", 32'(grants[3]), 32'h22);
    tick(); tick();

    // Reset during WAIT_IC with ic_read held
    lat = 6; mem_readdata = 32'hC3C3C3C3;
    ic_read = 1'b1; ic_address = 6'h03;
    tick(); tick(); tick();
    chk("t5_pre_reset_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_mem_read", 32'(mem_read), 32'd0);
    chk("t5_rst_ic_readdata", ic_readdata, 32'd0);
    chk("t5_rst_dc_readdata", dc_readdata, 32'd0);
    chk("t5_rst_ic_busy", 32'(ic_busywait), 32'd1);
    tick();
    chk("t5_restart_read", 32'(mem_read), 32'd1);
    chk("t5_restart_addr", 32'(mem_address), 32'h03);
    wait_release(1'b1, n);
    chk("t5_restart_latency", 32'(n), 32'd7);
    chk("t5_ic_readdata", ic_readdata, 32'hC3C3C3C3);
    ic_read = 1'b0;
    tick();

    // dc_read and dc_write together are no request
    lat = 1;
    dc_read = 1'b1; dc_write = 1'b1;
    tick();
    chk("t6_dc_busy", 32'(dc_busywait), 32'd0);
    chk("t6_no_access", 32'({mem_read, mem_write}), 32'd0);
    tick();
    chk("t6_still_no_access", 32'({mem_read, mem_write}), 32'd0);
    dc_read = 1'b0; dc_write = 1'b0;
    ic_read = 1'b1; ic_address = 6'h05;
    tick();
    chk("t6_idle_grant_addr", 32'(mem_address), 32'h05);
    chk("t6_idle_grant_read", 32'(mem_read), 32'd1);
    wait_release(1'b1, n);
    chk("t6_ic_latency", 32'(n), 32'd2);
    ic_read = 1'b0;
    tick();

    chk("never_read_and_write", 32'(both_hi), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
